// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared mode encoding and width helper for the channel arbiter
package mux_arbiter_pkg;
    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mux_arbiter_rr_grant.sv
// rr_grant: combinational rotating-priority finder starting just after ptr
module rr_grant #(
    parameter int NUM_CH = 32,
    parameter int SEL_W  = 5
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    always_comb begin
        dbl       = {req, req};
        rot       = NUM_CH'(dbl >> (32'(ptr) + 32'd1));
        gnt_valid = |req;
        gnt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (rot[i]) gnt_idx = SEL_W'((32'(ptr) + 32'd1 + 32'(i)) % NUM_CH);
    end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: N-to-1 valid/ready selector, fixed or round-robin, registered output
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 32,
    parameter  int DATA_W = 5,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              in_valid,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               sel,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic [SEL_W-1:0]               out_chan,
    input  logic                           out_ready
);
    mux_mode_t          mode_e;
    logic               rr_v, gnt_v, load_ok, xfer;
    logic [SEL_W-1:0]   rr_idx, gnt;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SEL_W-1:0]   chan_q, chan_d, ptr_q, ptr_d;

    rr_grant #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_rr (
        .req(in_valid), .ptr(ptr_q), .gnt_valid(rr_v), .gnt_idx(rr_idx)
    );

    // rst_n gates the handshake so a reset mid-transfer drops in_ready at once
    always_comb begin
        mode_e   = mux_mode_t'(mode);
        gnt      = (mode_e == MODE_RR) ? rr_idx : sel;
        gnt_v    = (mode_e == MODE_RR) ? rr_v : ((32'(sel) < NUM_CH) && in_valid[sel]);
        load_ok  = !valid_q || out_ready;
        xfer     = rst_n && gnt_v && load_ok;
        in_ready = xfer ? (NUM_CH'(1) << gnt) : '0;
        valid_d  = xfer || (valid_q && !out_ready);
        data_d   = xfer ? in_data[gnt] : data_q;
        chan_d   = xfer ? gnt : chan_q;
        ptr_d    = (xfer && mode_e == MODE_RR) ? gnt : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_mux_arbiter;
    localparam int N = 32;
    localparam int W = 5;

    logic              clk, rst_n, mode, out_ready, out_valid;
    logic [N-1:0]      in_valid, in_ready;
    logic [N-1:0][W-1:0] in_data;
    logic [4:0]        sel, out_chan;
    logic [W-1:0]      out_data;

    int errs = 0, checks = 0;
    int mptr, mchan;
    bit mvalid;
    logic [W-1:0] mdata;

    mux_arbiter #(.NUM_CH(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // model grant: index of winning channel, or -1 for none
    function automatic int mgrant();
        if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++)
            if (in_valid[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = mgrant();
        if (!rst_n || g < 0 || !(!mvalid || out_ready)) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_reset();
        mvalid = 0; mdata = '0; mchan = 0; mptr = N - 1;
    endtask

    task automatic tick();
        logic [N-1:0] r;
        int g;
        logic [W-1:0] d;
        r = exp_ready();
        g = mgrant();
        if (g >= 0) d = in_data[g];
        @(posedge clk);
        if (r != 0) begin
            mvalid = 1; mdata = d; mchan = g;
            if (mode) mptr = g;
        end else if (out_ready) mvalid = 0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = '1; mode = 1; sel = 0; out_ready = 1;
        for (int i = 0; i < N; i++) in_data[i] = W'(i + 3);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== '0) begin errs++; $display("FAIL reset_data got=%h want=0", out_data); end
        checks++; if (out_chan !== '0) begin errs++; $display("FAIL reset_chan got=%0d want=0", out_chan); end
        checks++; if (in_ready !== '0) begin errs++; $display("FAIL reset_ready got=%h want=0", in_ready); end
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 32'h1) begin errs++; $display("FAIL first_rr_ready got=%h want=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_chan !== 5'd0 || out_data !== 5'd3) begin
            errs++; $display("FAIL first_xfer got=%b/%0d/%h want=1/0/03", out_valid, out_chan, out_data); end
    endtask

    task automatic test_fixed();
        mode = 0; sel = 5; in_valid = 32'h0000_0020; in_data[5] = 5'h1A; out_ready = 1;
        #1;
        checks++; if (in_ready !== 32'h20) begin errs++; $display("FAIL fixed_ready got=%h want=20", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 5'h1A || out_chan !== 5'd5) begin
            errs++; $display("FAIL fixed_out got=%b/%h/%0d want=1/1a/5", out_valid, out_data, out_chan); end
        sel = 6;
        #1;
        checks++; if (in_ready !== '0) begin errs++; $display("FAIL fixed_invalid_ready got=%h want=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fixed_no_xfer got=%b want=0", out_valid); end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        mode = 1; in_valid = '1; out_ready = 1;
        for (int i = 0; i < N; i++) in_data[i] = W'(i);
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_chan !== 5'(i % N) || out_data !== 5'(i % N)) begin
                errs++; $display("FAIL rr_seq[%0d] got=%b/%0d/%0d want=1/%0d/%0d", i, out_valid, out_chan, out_data, i % N, i % N); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== '0) begin errs++; $display("FAIL stall_ready[%0d] got=%h want=0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_chan !== 5'd7 || out_data !== 5'd7) begin
                errs++; $display("FAIL stall_hold[%0d] got=%b/%0d/%0d want=1/7/7", i, out_valid, out_chan, out_data); end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 32'h100) begin errs++; $display("FAIL drain_ready got=%h want=100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_chan !== 5'd8) begin
            errs++; $display("FAIL drain_reload got=%b/%0d want=1/8", out_valid, out_chan); end
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        mode = 1; out_ready = 1; in_valid = 32'h4000_0000;
        tick();
        in_valid = 32'h8000_0004;
        #1;
        checks++; if (in_ready !== 32'h8000_0000) begin errs++; $display("FAIL wrap_ready31 got=%h want=80000000", in_ready); end
        tick();
        checks++; if (out_chan !== 5'd31) begin errs++; $display("FAIL wrap_chan31 got=%0d want=31", out_chan); end
        #1;
        checks++; if (in_ready !== 32'h4) begin errs++; $display("FAIL wrap_ready2 got=%h want=4", in_ready); end
        tick();
        checks++; if (out_chan !== 5'd2) begin errs++; $display("FAIL wrap_chan2 got=%0d want=2", out_chan); end
        in_valid = '1;
        #1;
        checks++; if (in_ready !== 32'h8) begin errs++; $display("FAIL wrap_ptr2 got=%h want=8", in_ready); end
    endtask

    task automatic test_async_reset();
        tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== '0) begin
            errs++; $display("FAIL async_reset got=%b/%h/%h want=0/0/0", out_valid, out_data, in_ready); end
        @(negedge clk);
        rst_n = 1; mode = 1; in_valid = '1;
        #1;
        checks++; if (in_ready !== 32'h1) begin errs++; $display("FAIL async_ptr got=%h want=1", in_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom();
            if ($urandom_range(3) == 0) in_valid = N'(1) << $urandom_range(N - 1);
            for (int i = 0; i < N; i++) in_data[i] = W'($urandom());
            mode = 1'($urandom_range(3) != 0);
            sel = 5'($urandom());
            out_ready = 1'($urandom_range(3) != 0);
            #1;
            checks++; if (in_ready !== exp_ready()) begin
                errs++; $display("FAIL rand_ready[%0d] got=%h want=%h", c, in_ready, exp_ready()); end
            tick();
            checks++; if (out_valid !== mvalid || out_data !== mdata || out_chan !== 5'(mchan)) begin
                errs++; $display("FAIL rand_out[%0d] got=%b/%h/%0d want=%b/%h/%0d", c, out_valid, out_data, out_chan, mvalid, mdata, mchan); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Parametrised N-to-1 channel selector with per-channel valid/ready handshakes and a registered output stage.
- Successor to the enable-strobed selector: it adds a clock, backpressure, and runtime mode selection.
- Fixed mode forwards the channel named by `sel`; round-robin mode arbitrates fairly among all valid channels.
- Sits between multiple memory-request sources and a single memory port.

Parameters:
- NUM_CH, 32, number of input channels (>= 2).
- DATA_W, 5, payload width per channel.
- SEL_W, $clog2(NUM_CH), derived localparam: width of `sel`, `out_chan` and the round-robin pointer.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  NUM_CH  per-channel request valid.
- in_data  input  [NUM_CH-1:0][DATA_W-1:0]  per-channel payload.
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_valid  output  1  output register holds data.
- out_data  output  DATA_W  registered payload.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, rst_n low):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=NUM_CH-1, so the first search starts at channel 0.
  - Reset mid-transfer discards the held word; in_ready goes to 0 immediately.
- load_ok = !out_valid || out_ready (register empty, or draining this cycle).
- Grant (combinational):
  - Fixed mode: grant=sel if sel<NUM_CH && in_valid[sel]; otherwise no grant. Out-of-range sel never grants.
  - RR mode: grant is the first channel with in_valid set, searching ptr+1, ptr+2, … with wrap modulo NUM_CH. No valid channel means no grant.
- in_ready[grant] = load_ok; all other bits are 0. in_ready never has more than one bit set.
- Transfer on in_valid[g] && in_ready[g]. Next cycle: out_valid=1, out_data=in_data[g], out_chan=g. Latency is 1 cycle from input transfer to out_valid.
- Output drain on out_valid && out_ready:
  - With a simultaneous load, the register is replaced and out_valid stays 1 (full throughput, 1 word/cycle).
  - Without a load, out_valid goes to 0.
- Stall (out_valid && !out_ready): out_data and out_chan hold stable; all in_ready=0.
- Pointer update:
  - ptr<=g only on a transfer while mode=1.
  - Unchanged in fixed mode and on cycles without a transfer.
- Mode/sel changes:
  - Sampled combinationally every cycle; no flush and no effect on a word already held.
  - Switching fixed→RR resumes the search from the stored ptr.
- Fairness: in RR mode with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_CH-1,0,… with no repeats.
- Inputs are not required to hold after in_valid drops without a transfer; no state is kept per channel.

Decomposition:
- Package mux_arbiter_pkg holds:
  - Typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_t.
  - A function returning SEL_W for a given NUM_CH.
- One sub-module, rr_grant: purely combinational rotating-priority finder.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Implemented via a doubled request vector.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, in_ready=0. Release: first RR grant is channel 0, and out_valid rises one cycle after the transfer.
- Fixed mode: sel=5, in_valid=32'h0000_0020, in_data[5]=5'h1A → in_ready=32'h20, then out_data=5'h1A, out_chan=5. Set sel=6 with ch6 invalid → in_ready=0, no transfer.
- RR fairness: all in_valid=1, out_ready=1, in_data[i]=i, 40 cycles → out_chan sequence 0..31,0..7, one word every cycle.
- Backpressure: out_ready=0 for 4 cycles while full → out_data/out_chan stable, in_ready=0. out_ready=1 with a pending request → drain and reload in the same cycle, out_valid stays 1.
- Sparse RR with wrap: ptr=30, in_valid has bits 2 and 31 set → grants 31 then 2, then ptr=2.
- Async reset mid-operation: assert rst_n low between clock edges while out_valid=1 → out_valid=0 immediately, before the next edge. After release, ptr=NUM_CH-1.
